// File: rtl/sram_model_pkg.sv
// Shared types and helpers for the 1RW1R synchronous SRAM model: FSM state,
// read-during-write mode encodings, byte-mask expansion and parameter legality.
package sram_model_pkg;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } sram_state_t;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  // Upper bound on byte lanes the mask helper handles (1024-bit words).
  localparam int MAX_MASKS = 128;

  function automatic logic [MAX_MASKS*8-1:0] expand_byte_mask(input logic [MAX_MASKS-1:0] mask);
    logic [MAX_MASKS*8-1:0] bits;
    bits = '0;
    for (int i = 0; i < MAX_MASKS; i++) begin
      bits[8*i +: 8] = {8{mask[i]}};
    end
    return bits;
  endfunction

  function automatic bit sram_params_ok(input int data_width, input int read_latency);
    return (data_width > 0) && (data_width % 8 == 0) && (data_width <= MAX_MASKS*8) &&
           (read_latency == 1 || read_latency == 2);
  endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// Read-data and valid delay line; data only advances alongside a valid so the
// output holds the last read value between reads.
module sram_rd_pipe #(
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_vld,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_vld,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic                  r_vld_p0;
  logic [DATA_WIDTH-1:0] r_data_p0;

  // Stage p0: capture the array word sampled at the request edge
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_vld_p0  <= 1'b0;
      r_data_p0 <= '0;
    end else begin
      r_vld_p0 <= i_vld;
      if (i_vld) r_data_p0 <= i_data;
    end
  end

  if (READ_LATENCY == 2) begin : g_p1
    logic                  r_vld_p1;
    logic [DATA_WIDTH-1:0] r_data_p1;

    // Stage p1: optional second register for the two-cycle latency build
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_vld_p1  <= 1'b0;
        r_data_p1 <= '0;
      end else begin
        r_vld_p1 <= r_vld_p0;
        if (r_vld_p0) r_data_p1 <= r_data_p0;
      end
    end

    assign o_vld  = r_vld_p1;
    assign o_data = r_data_p1;
  end else begin : g_p0
    assign o_vld  = r_vld_p0;
    assign o_data = r_data_p0;
  end

endmodule

// File: rtl/sram_1rw1r_sync_model.sv
// Synthesizable 1RW1R SRAM: byte-masked port 0, read-only port 1, shared clock,
// configurable read latency, defined read-during-write and a reset clear sweep.
module sram_1rw1r_sync_model
  import sram_model_pkg::*;
#(
  parameter  int DATA_WIDTH     = 32,
  parameter  int ADDR_WIDTH     = 8,
  parameter  int READ_LATENCY   = 1,
  parameter  int RDW_MODE       = RDW_OLD,
  parameter  int CLEAR_ON_RESET = 1,
  localparam int NUM_WMASKS     = DATA_WIDTH / 8
) (
  input  logic                  clk0,
  input  logic                  rst0,
  input  logic                  csb0,
  input  logic                  web0,
  input  logic [NUM_WMASKS-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  output logic [DATA_WIDTH-1:0] dout0,
  output logic                  dout0_valid,
  input  logic                  csb1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic [DATA_WIDTH-1:0] dout1,
  output logic                  dout1_valid,
  output logic                  collision,
  output logic                  init_busy
);

  localparam int RAM_DEPTH = 2 ** ADDR_WIDTH;

  if (!sram_params_ok(DATA_WIDTH, READ_LATENCY)) begin : g_bad_params
    $error("sram_1rw1r_sync_model: DATA_WIDTH must be a multiple of 8 and READ_LATENCY 1 or 2");
  end

  logic [DATA_WIDTH-1:0] r_mem [RAM_DEPTH];
  sram_state_t           r_state;
  logic [ADDR_WIDTH-1:0] r_clear_addr;
  logic                  r_init_busy;

  logic                  w_ready;
  logic                  w_wr0;
  logic                  w_rd0;
  logic                  w_rd1;
  logic                  w_collision;
  logic [DATA_WIDTH-1:0] w_bitmask;
  logic [DATA_WIDTH-1:0] w_old1;
  logic [DATA_WIDTH-1:0] w_rdata1;
  logic [DATA_WIDTH:0]   w_pipe1_data;

  // A request on the reset edge is dropped along with everything in flight.
  assign w_ready     = (r_state == ST_READY) && !rst0;
  assign w_wr0       = w_ready && !csb0 && !web0;
  assign w_rd0       = w_ready && !csb0 && web0;
  assign w_rd1       = w_ready && !csb1;
  assign w_collision = w_wr0 && w_rd1 && (addr0 == addr1);
  assign w_bitmask   = DATA_WIDTH'(expand_byte_mask(MAX_MASKS'(wmask0)));
  assign w_old1      = r_mem[addr1];
  assign w_rdata1    = (RDW_MODE == RDW_NEW && w_collision)
                       ? ((din0 & w_bitmask) | (w_old1 & ~w_bitmask)) : w_old1;

  always_ff @(posedge clk0) begin
    if (rst0) begin
      r_state      <= (CLEAR_ON_RESET != 0) ? ST_INIT : ST_READY;
      r_clear_addr <= '0;
      r_init_busy  <= (CLEAR_ON_RESET != 0);
    end else if (r_state == ST_INIT) begin
      r_clear_addr <= r_clear_addr + ADDR_WIDTH'(1);
      if (r_clear_addr == ADDR_WIDTH'(RAM_DEPTH - 1)) begin
        r_state      <= ST_READY;
        r_init_busy  <= 1'b0;
        r_clear_addr <= '0;
      end
    end
  end

  always_ff @(posedge clk0) begin
    if (!rst0 && r_state == ST_INIT) begin
      r_mem[r_clear_addr] <= '0;
    end else if (w_wr0) begin
      r_mem[addr0] <= (din0 & w_bitmask) | (r_mem[addr0] & ~w_bitmask);
    end
  end

  sram_rd_pipe #(
    .DATA_WIDTH  (DATA_WIDTH),
    .READ_LATENCY(READ_LATENCY)
  ) u_rd_pipe0 (
    .i_clk (clk0),
    .i_rst (rst0),
    .i_vld (w_rd0),
    .i_data(r_mem[addr0]),
    .o_vld (dout0_valid),
    .o_data(dout0)
  );

  // The collision flag rides in the port-1 pipe so it lines up with dout1_valid.
  sram_rd_pipe #(
    .DATA_WIDTH  (DATA_WIDTH + 1),
    .READ_LATENCY(READ_LATENCY)
  ) u_rd_pipe1 (
    .i_clk (clk0),
    .i_rst (rst0),
    .i_vld (w_rd1),
    .i_data({w_collision, w_rdata1}),
    .o_vld (dout1_valid),
    .o_data(w_pipe1_data)
  );

  assign dout1     = w_pipe1_data[DATA_WIDTH-1:0];
  assign collision = dout1_valid && w_pipe1_data[DATA_WIDTH];
  assign init_busy = r_init_busy;

endmodule

// File: tb/tb_sram_1rw1r_sync_model.sv
// Scoreboard bench: two instances (latency 1 / old-data RDW, latency 2 / new-data
// RDW) share one stimulus stream; per-port monitors pop expected reads.
module tb_sram_1rw1r_sync_model;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0, csb0, web0, csb1;
  logic [3:0]  wmask0;
  logic [7:0]  addr0, addr1;
  logic [31:0] din0;

  logic [31:0] a_d0, a_d1, b_d0, b_d1;
  logic        a_v0, a_v1, a_coll, a_busy;
  logic        b_v0, b_v1, b_coll, b_busy;

  sram_1rw1r_sync_model #(
    .DATA_WIDTH(32), .ADDR_WIDTH(8), .READ_LATENCY(1), .RDW_MODE(0), .CLEAR_ON_RESET(1)
  ) dut_a (
    .clk0(clk), .rst0(rst0), .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0),
    .din0(din0), .dout0(a_d0), .dout0_valid(a_v0), .csb1(csb1), .addr1(addr1),
    .dout1(a_d1), .dout1_valid(a_v1), .collision(a_coll), .init_busy(a_busy)
  );

  sram_1rw1r_sync_model #(
    .DATA_WIDTH(32), .ADDR_WIDTH(8), .READ_LATENCY(2), .RDW_MODE(1), .CLEAR_ON_RESET(1)
  ) dut_b (
    .clk0(clk), .rst0(rst0), .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0),
    .din0(din0), .dout0(b_d0), .dout0_valid(b_v0), .csb1(csb1), .addr1(addr1),
    .dout1(b_d1), .dout1_valid(b_v1), .collision(b_coll), .init_busy(b_busy)
  );

  typedef struct {
    logic [31:0] data;
    logic        coll;
    int          due;
  } exp_t;

  exp_t q0a[$], q1a[$], q0b[$], q1b[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t mk(input logic [31:0] d, input logic c, input int due);
    exp_t e;
    e.data = d;
    e.coll = c;
    e.due  = due;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic mon_pop(input string nm, input exp_t e, input logic [31:0] d,
                         input logic c, input bit chk_coll);
    chk({nm, "_data"}, d, e.data);
    chk({nm, "_latency"}, 32'(cyc), 32'(e.due));
    if (chk_coll) chk({nm, "_collision"}, {31'b0, c}, {31'b0, e.coll});
  endtask

  always @(negedge clk) begin
    if (q0a.size() > 0 && q0a[0].due < cyc) begin
      chk("p0a_missing_valid", 32'(cyc), 32'(q0a[0].due)); void'(q0a.pop_front());
    end
    if (a_v0) begin
      if (q0a.size() == 0) chk("p0a_unexpected_valid", {31'b0, a_v0}, 32'd0);
      else mon_pop("p0a", q0a.pop_front(), a_d0, 1'b0, 1'b0);
    end
  end

  always @(negedge clk) begin
    if (q1a.size() > 0 && q1a[0].due < cyc) begin
      chk("p1a_missing_valid", 32'(cyc), 32'(q1a[0].due)); void'(q1a.pop_front());
    end
    if (a_v1) begin
      if (q1a.size() == 0) chk("p1a_unexpected_valid", {31'b0, a_v1}, 32'd0);
      else mon_pop("p1a", q1a.pop_front(), a_d1, a_coll, 1'b1);
    end else if (a_coll) chk("p1a_stray_collision", {31'b0, a_coll}, 32'd0);
  end

  always @(negedge clk) begin
    if (q0b.size() > 0 && q0b[0].due < cyc) begin
      chk("p0b_missing_valid", 32'(cyc), 32'(q0b[0].due)); void'(q0b.pop_front());
    end
    if (b_v0) begin
      if (q0b.size() == 0) chk("p0b_unexpected_valid", {31'b0, b_v0}, 32'd0);
      else mon_pop("p0b", q0b.pop_front(), b_d0, 1'b0, 1'b0);
    end
  end

  always @(negedge clk) begin
    if (q1b.size() > 0 && q1b[0].due < cyc) begin
      chk("p1b_missing_valid", 32'(cyc), 32'(q1b[0].due)); void'(q1b.pop_front());
    end
    if (b_v1) begin
      if (q1b.size() == 0) chk("p1b_unexpected_valid", {31'b0, b_v1}, 32'd0);
      else mon_pop("p1b", q1b.pop_front(), b_d1, b_coll, 1'b1);
    end else if (b_coll) chk("p1b_stray_collision", {31'b0, b_coll}, 32'd0);
  end

  // Drive one cycle of inputs right after a falling edge; push[0]/push[1]
  // select whether instance a/b is expected to answer the reads.
  task automatic step(input logic c0, input logic w0, input logic [3:0] m,
                      input logic [7:0] a0, input logic [31:0] d0,
                      input logic c1, input logic [7:0] a1,
                      input logic [31:0] e0, input logic [31:0] e1a, input logic [31:0] e1b,
                      input logic coll, input logic [1:0] push);
    csb0 = c0; web0 = w0; wmask0 = m; addr0 = a0; din0 = d0; csb1 = c1; addr1 = a1;
    if (push[0]) begin
      if (!c0 && w0) q0a.push_back(mk(e0, 1'b0, cyc + 1));
      if (!c1)       q1a.push_back(mk(e1a, coll, cyc + 1));
    end
    if (push[1]) begin
      if (!c0 && w0) q0b.push_back(mk(e0, 1'b0, cyc + 2));
      if (!c1)       q1b.push_back(mk(e1b, coll, cyc + 2));
    end
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b1, 1'b1, 4'h0, 8'h00, 32'h0, 1'b1, 8'h00, 32'h0, 32'h0, 32'h0, 1'b0, 2'b00);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] m);
    step(1'b0, 1'b0, m, a, d, 1'b1, 8'h00, 32'h0, 32'h0, 32'h0, 1'b0, 2'b11);
  endtask

  task automatic rd(input logic [7:0] a0, input logic [31:0] e0,
                    input logic [7:0] a1, input logic [31:0] e1);
    step(1'b0, 1'b1, 4'h0, a0, 32'h0, 1'b0, a1, e0, e1, e1, 1'b0, 2'b11);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_a_dout0"}, a_d0, 32'h0);
    chk({tag, "_a_dout1"}, a_d1, 32'h0);
    chk({tag, "_a_flags"}, {28'b0, a_v0, a_v1, a_coll, a_busy}, 32'h1);
    chk({tag, "_b_dout0"}, b_d0, 32'h0);
    chk({tag, "_b_dout1"}, b_d1, 32'h0);
    chk({tag, "_b_flags"}, {28'b0, b_v0, b_v1, b_coll, b_busy}, 32'h1);
  endtask

  // Counts init_busy cycles; requests issued meanwhile must be ignored.
  task automatic run_init(input string tag);
    int na = 0;
    int nb = 0;
    int n  = 0;
    while ((a_busy || b_busy) && n < 1000) begin
      if (a_busy) na++;
      if (b_busy) nb++;
      n++;
      case (n)
        10:      step(1'b0, 1'b1, 4'h0, 8'h01, 32'h0, 1'b0, 8'h02, 32'h0, 32'h0, 32'h0, 1'b0, 2'b00);
        11:      step(1'b0, 1'b1, 4'h0, 8'h02, 32'h0, 1'b0, 8'h01, 32'h0, 32'h0, 32'h0, 1'b0, 2'b00);
        250:     step(1'b0, 1'b0, 4'hF, 8'h05, 32'hCAFEF00D, 1'b1, 8'h00, 32'h0, 32'h0, 32'h0, 1'b0, 2'b00);
        251:     step(1'b0, 1'b0, 4'hF, 8'h01, 32'hFFFFFFFF, 1'b0, 8'h01, 32'h0, 32'h0, 32'h0, 1'b0, 2'b00);
        default: idle();
      endcase
    end
    chk({tag, "_len_a"}, 32'(na), 32'd256);
    chk({tag, "_len_b"}, 32'(nb), 32'd256);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst0 = 1'b1; csb0 = 1'b1; web0 = 1'b1; csb1 = 1'b1;
    wmask0 = 4'h0; addr0 = 8'h0; addr1 = 8'h0; din0 = 32'h0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst0 = 1'b0;
    run_init("init1");

    // Cleared contents, and writes attempted during INIT must not have landed
    rd(8'hFF, 32'h0, 8'hFF, 32'h0);
    rd(8'h05, 32'h0, 8'h01, 32'h0);
    wr(8'h01, 32'h0101A5A5, 4'hF);
    rd(8'h01, 32'h0101A5A5, 8'h02, 32'h0);

    wr(8'h10, 32'hDEADBEEF, 4'hF);
    wr(8'h10, 32'h11223344, 4'b0101);
    rd(8'h10, 32'hDE22BE44, 8'h10, 32'hDE22BE44);

    wr(8'h20, 32'h12345678, 4'hF);
    step(1'b0, 1'b0, 4'b0011, 8'h20, 32'hAAAAAAAA, 1'b0, 8'h20,
         32'h0, 32'h12345678, 32'h1234AAAA, 1'b1, 2'b11);
    rd(8'h20, 32'h1234AAAA, 8'h20, 32'h1234AAAA);

    step(1'b0, 1'b0, 4'hF, 8'h30, 32'h00000055, 1'b0, 8'h10,
         32'h0, 32'hDE22BE44, 32'hDE22BE44, 1'b0, 2'b11);
    rd(8'h30, 32'h00000055, 8'h10, 32'hDE22BE44);

    wr(8'h10, 32'hFFFFFFFF, 4'h0);
    rd(8'h10, 32'hDE22BE44, 8'h10, 32'hDE22BE44);

    wr(8'h03, 32'h03030303, 4'hF);
    wr(8'h04, 32'h04040404, 4'hF);
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) rd(8'h03, 32'h03030303, 8'h03, 32'h03030303);
      else            rd(8'h04, 32'h04040404, 8'h04, 32'h04040404);
    end
    repeat (3) idle();
    chk("hold_a_dout0", a_d0, 32'h04040404);
    chk("hold_b_dout1", b_d1, 32'h04040404);

    // Reset one cycle after a read: latency-1 instance answers, latency-2 drops it
    step(1'b0, 1'b1, 4'h0, 8'h10, 32'h0, 1'b0, 8'h20,
         32'hDE22BE44, 32'h1234AAAA, 32'h1234AAAA, 1'b0, 2'b01);
    rst0 = 1'b1;
    idle();
    chk_reset_outputs("rst_midread");
    rst0 = 1'b0;
    repeat (128) idle();
    chk("midinit_busy", {30'b0, a_busy, b_busy}, 32'h3);
    rst0 = 1'b1;
    idle();
    chk_reset_outputs("rst_midinit");
    rst0 = 1'b0;
    run_init("init2");

    rd(8'h10, 32'h0, 8'h20, 32'h0);
    rd(8'h01, 32'h0, 8'h04, 32'h0);
    repeat (4) idle();
    chk("scoreboard_drained", 32'(q0a.size() + q1a.size() + q0b.size() + q1b.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
